queue_meta_rr: RTL and testbench

QUEUE_META_RR -- requirements
Module: queue_meta_rr

---
 rtl/queue_meta_rr.sv | 155 +++++++++++++++
 tb/tb_queue_meta_rr.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_meta_rr.sv
`default_nettype none
// ============================================================================
// Module   : queue_meta_rr
// Purpose  : Per-channel meta FIFOs merged onto one stream by a locked
//            round-robin arbiter. Define QUEUE_META_RR_STATS_EN to build the
//            per-channel dequeue counters (deq_cnt reads 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module queue_meta_rr #(
  parameter  int N_CHAN    = 4,
  parameter  int DATA_BITS = 64,
  parameter  int QDEPTH    = 8,
  parameter  int AFULL_THR = QDEPTH - 2,
  localparam int CW        = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int OW        = $clog2(QDEPTH) + 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_CHAN-1:0]           s_meta_valid,
  output logic [N_CHAN-1:0]           s_meta_ready,
  input  logic [N_CHAN*DATA_BITS-1:0] s_meta_data,
  output logic                        m_meta_valid,
  input  logic                        m_meta_ready,
  output logic [DATA_BITS-1:0]        m_meta_data,
  output logic [CW-1:0]               m_meta_chan,
  output logic [N_CHAN*OW-1:0]        occ,
  output logic [N_CHAN-1:0]           afull,
  output logic [N_CHAN*32-1:0]        deq_cnt
);

  localparam int            AW       = $clog2(QDEPTH);
  localparam int            CW1      = CW + 1;
  localparam logic [OW-1:0] c_qdepth = OW'(QDEPTH);
  localparam logic [OW-1:0] c_afull  = OW'(AFULL_THR);
  localparam logic [CW-1:0] c_last   = CW'(N_CHAN - 1);

  logic                 r_run;
  logic [CW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_gnt_chan;
  logic                 r_gnt_held;
  logic [N_CHAN-1:0]    w_enq;
  logic [N_CHAN-1:0]    w_deq;
  logic [N_CHAN-1:0]    w_nonempty;
  logic [DATA_BITS-1:0] w_head [N_CHAN];
  logic                 w_arb_found;
  logic [CW-1:0]        w_arb_chan;
  logic [CW1-1:0]       w_rr_sum;
  logic [CW-1:0]        w_sel;
  logic                 w_hs;

  // Ready is held off until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  generate
    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
      logic [DATA_BITS-1:0] r_mem [QDEPTH];
      logic [AW-1:0]        r_wr_ptr;
      logic [AW-1:0]        r_rd_ptr;
      logic [OW-1:0]        r_occ;

      assign w_nonempty[i]        = (r_occ != '0);
      assign s_meta_ready[i]      = r_run && (r_occ < c_qdepth);
      assign w_enq[i]             = s_meta_valid[i] && s_meta_ready[i];
      assign w_deq[i]             = w_hs && (w_sel == CW'(i));
      assign occ[i*OW +: OW]      = r_occ;
      assign afull[i]             = (r_occ >= c_afull);
      assign w_head[i]            = r_mem[r_rd_ptr];

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_occ    <= '0;
        end else begin
          if (w_enq[i]) r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_deq[i]) r_rd_ptr <= r_rd_ptr + AW'(1);
          case ({w_enq[i], w_deq[i]})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
          endcase
        end
      end

      // Storage is deliberately left out of reset; the pointers gate it.
      always_ff @(posedge aclk) begin
        if (w_enq[i]) r_mem[r_wr_ptr] <= s_meta_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  endgenerate

  // First non-empty channel at or above rr_ptr, wrapping modulo N_CHAN.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_chan  = '0;
    w_rr_sum    = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + CW1'(k);
      if (w_rr_sum >= CW1'(N_CHAN)) w_rr_sum = w_rr_sum - CW1'(N_CHAN);
      if (!w_arb_found && w_nonempty[w_rr_sum[CW-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_chan  = w_rr_sum[CW-1:0];
      end
    end
  end

  assign w_sel        = r_gnt_held ? r_gnt_chan : w_arb_chan;
  assign m_meta_valid = r_gnt_held || w_arb_found;
  assign w_hs         = m_meta_valid && m_meta_ready;
  assign m_meta_chan  = w_sel;

  always_comb begin
    m_meta_data = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (w_sel == CW'(k)) m_meta_data = w_head[k];
    end
  end

  // A stalled offer is locked so later arrivals cannot preempt it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rr_ptr   <= '0;
      r_gnt_chan <= '0;
      r_gnt_held <= 1'b0;
    end else if (w_hs) begin
      r_gnt_held <= 1'b0;
      r_rr_ptr   <= (w_sel == c_last) ? '0 : w_sel + CW'(1);
    end else if (m_meta_valid) begin
      r_gnt_held <= 1'b1;
      r_gnt_chan <= w_sel;
    end
  end

`ifdef QUEUE_META_RR_STATS_EN
  generate
    for (genvar i = 0; i < N_CHAN; i++) begin : g_stats
      logic [31:0] r_deq_cnt;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)      r_deq_cnt <= '0;
        else if (w_deq[i]) r_deq_cnt <= r_deq_cnt + 32'd1;
      end

      assign deq_cnt[i*32 +: 32] = r_deq_cnt;
    end
  endgenerate
`else
  assign deq_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_queue_meta_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_meta_rr
// Purpose  : Self-checking bench for queue_meta_rr against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_meta_rr;

  localparam int NC  = 4;
  localparam int DB  = 64;
  localparam int QD  = 8;
  localparam int AFT = QD - 2;
  localparam int CW  = 2;
  localparam int OW  = 4;
`ifdef QUEUE_META_RR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             aclk         = 1'b0;
  logic             aresetn      = 1'b1;
  logic [NC-1:0]    s_meta_valid = '0;
  logic [NC-1:0]    s_meta_ready;
  logic [NC*DB-1:0] s_meta_data  = '0;
  logic             m_meta_valid;
  logic             m_meta_ready = 1'b0;
  logic [DB-1:0]    m_meta_data;
  logic [CW-1:0]    m_meta_chan;
  logic [NC*OW-1:0] occ;
  logic [NC-1:0]    afull;
  logic [NC*32-1:0] deq_cnt;

  int total = 0;
  int bad   = 0;

  queue_meta_rr dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_meta_valid(s_meta_valid),
    .s_meta_ready(s_meta_ready),
    .s_meta_data (s_meta_data),
    .m_meta_valid(m_meta_valid),
    .m_meta_ready(m_meta_ready),
    .m_meta_data (m_meta_data),
    .m_meta_chan (m_meta_chan),
    .occ         (occ),
    .afull       (afull),
    .deq_cnt     (deq_cnt)
  );

  always #5 aclk = ~aclk;

  // Reference model: one word queue per channel plus arbitration state.
  typedef logic [DB-1:0] word_q_t [$];
  word_q_t mq [NC];
  int  rr, hchan;
  int  dcnt [NC];
  bit  held, run;

  bit               e_valid;
  int               e_chan;
  logic [DB-1:0]    e_data;
  logic [NC-1:0]    e_ready, e_afull;
  logic [NC*OW-1:0] e_occ;
  logic [NC*32-1:0] e_deq;

  function automatic void model_eval();
    e_valid = held;
    e_chan  = held ? hchan : 0;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (rr + k) % NC;
      if (!e_valid && mq[c].size() > 0) begin
        e_valid = 1'b1;
        e_chan  = c;
      end
    end
    e_data = '0;
    if (e_valid) e_data = mq[e_chan][0];
    for (int i = 0; i < NC; i++) begin
      e_ready[i]          = run && (mq[i].size() < QD);
      e_occ[i*OW +: OW]   = OW'(mq[i].size());
      e_afull[i]          = (mq[i].size() >= AFT);
      e_deq[i*32 +: 32]   = STATS ? 32'(dcnt[i]) : 32'd0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      dcnt[i] = 0;
    end
    rr = 0; hchan = 0; held = 1'b0; run = 1'b0;
    model_eval();
  endfunction

  // Applies the current inputs to the model, then advances one clock.
  task automatic step();
    for (int i = 0; i < NC; i++)
      if (s_meta_valid[i] && e_ready[i]) mq[i].push_back(s_meta_data[i*DB +: DB]);
    if (e_valid && m_meta_ready) begin
      void'(mq[e_chan].pop_front());
      dcnt[e_chan]++;
      rr   = (e_chan + 1) % NC;
      held = 1'b0;
    end else if (e_valid) begin
      held  = 1'b1;
      hchan = e_chan;
    end
    run = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    model_eval();
  endtask

  task automatic drive(input logic [NC-1:0] v, input logic [NC*DB-1:0] d, input logic mr);
    s_meta_valid = v;
    s_meta_data  = d;
    m_meta_ready = mr;
  endtask

  task automatic push1(input int ch, input logic [DB-1:0] w, input logic mr);
    s_meta_valid     = '0;
    s_meta_valid[ch] = 1'b1;
    s_meta_data      = '0;
    s_meta_data[ch*DB +: DB] = w;
    m_meta_ready     = mr;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive('0, '0, 1'b0);
    model_reset();
    repeat (2) @(negedge aclk);
    total++; if (m_meta_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", m_meta_valid); end
    total++; if (s_meta_ready !== '0) begin bad++; $display("FAIL rst_ready: got %0h want 0", s_meta_ready); end
    total++; if (occ !== '0) begin bad++; $display("FAIL rst_occ: got %0h want 0", occ); end
    total++; if (afull !== '0) begin bad++; $display("FAIL rst_afull: got %0h want 0", afull); end
    total++; if (deq_cnt !== '0) begin bad++; $display("FAIL rst_deq_cnt: got %0h want 0", deq_cnt); end
    aresetn = 1'b1;
    #1;
    total++; if (s_meta_ready !== '0) begin bad++; $display("FAIL rst_ready_pre_edge: got %0h want 0", s_meta_ready); end
    step();
    total++; if (s_meta_ready !== 4'hF) begin bad++; $display("FAIL rst_ready_post_edge: got %0h want f", s_meta_ready); end
  endtask

  task automatic test_rr_order();
    logic [NC*DB-1:0] d;
    d = '0;
    for (int i = 0; i < NC; i++) d[i*DB +: DB] = DB'(32'hA0 + i);
    drive(4'hF, d, 1'b1);
    step();
    drive('0, '0, 1'b1);
    for (int k = 0; k < NC; k++) begin
      total++; if (m_meta_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %0h want 1", k, m_meta_valid); end
      total++; if (m_meta_chan !== CW'(k)) begin bad++; $display("FAIL rr_chan[%0d]: got %0d want %0d", k, m_meta_chan, k); end
      total++; if (m_meta_data !== DB'(32'hA0 + k)) begin bad++; $display("FAIL rr_data[%0d]: got %0h want %0h", k, m_meta_data, 32'hA0 + k); end
      step();
    end
    total++; if (m_meta_valid !== 1'b0) begin bad++; $display("FAIL rr_idle: got %0h want 0", m_meta_valid); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < QD; k++) begin
      push1(2, DB'(32'h200 + k), 1'b0);
      total++; if (s_meta_ready[2] !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d]: got %0h want 1", k, s_meta_ready[2]); end
      total++; if (afull[2] !== 1'(k >= AFT)) begin bad++; $display("FAIL fill_afull[%0d]: got %0h want %0h", k, afull[2], k >= AFT); end
      step();
    end
    push1(2, DB'(32'h2FF), 1'b0);
    total++; if (s_meta_ready[2] !== 1'b0) begin bad++; $display("FAIL full_ready: got %0h want 0", s_meta_ready[2]); end
    total++; if (occ[2*OW +: OW] !== 4'd8) begin bad++; $display("FAIL full_occ: got %0d want 8", occ[2*OW +: OW]); end
    total++; if (afull[2] !== 1'b1) begin bad++; $display("FAIL full_afull: got %0h want 1", afull[2]); end
    step();
    step();
    total++; if (occ[2*OW +: OW] !== 4'd8) begin bad++; $display("FAIL full_no_accept: got %0d want 8", occ[2*OW +: OW]); end
    total++; if (m_meta_chan !== 2'd2) begin bad++; $display("FAIL full_chan: got %0d want 2", m_meta_chan); end
    drive('0, '0, 1'b1);
    for (int k = 0; k < QD; k++) begin
      total++; if (m_meta_data !== DB'(32'h200 + k)) begin bad++; $display("FAIL drain_data[%0d]: got %0h want %0h", k, m_meta_data, 32'h200 + k); end
      step();
    end
    total++; if (m_meta_valid !== 1'b0) begin bad++; $display("FAIL drain_idle: got %0h want 0", m_meta_valid); end
  endtask

  task automatic test_no_preempt();
    push1(3, DB'(32'h33FF), 1'b1);
    step();
    drive('0, '0, 1'b1);
    step();
    push1(3, DB'(32'h3300), 1'b0);
    step();
    total++; if (m_meta_chan !== 2'd3) begin bad++; $display("FAIL lock_first_chan: got %0d want 3", m_meta_chan); end
    push1(0, DB'(32'h0C00), 1'b0);
    step();
    drive('0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      total++; if (m_meta_chan !== 2'd3) begin bad++; $display("FAIL lock_chan[%0d]: got %0d want 3", k, m_meta_chan); end
      total++; if (m_meta_data !== DB'(32'h3300)) begin bad++; $display("FAIL lock_data[%0d]: got %0h want 3300", k, m_meta_data); end
      step();
    end
    drive('0, '0, 1'b1);
    step();
    total++; if (m_meta_chan !== 2'd0) begin bad++; $display("FAIL lock_next_chan: got %0d want 0", m_meta_chan); end
    total++; if (m_meta_data !== DB'(32'h0C00)) begin bad++; $display("FAIL lock_next_data: got %0h want c00", m_meta_data); end
    step();
  endtask

  task automatic test_push_pop();
    for (int k = 0; k < 4; k++) begin
      push1(1, DB'(32'h1100 + k), 1'b0);
      step();
    end
    total++; if (occ[1*OW +: OW] !== 4'd4) begin bad++; $display("FAIL pp_occ_before: got %0d want 4", occ[1*OW +: OW]); end
    push1(1, DB'(32'h1104), 1'b1);
    total++; if (m_meta_data !== DB'(32'h1100)) begin bad++; $display("FAIL pp_oldest: got %0h want 1100", m_meta_data); end
    step();
    total++; if (occ[1*OW +: OW] !== 4'd4) begin bad++; $display("FAIL pp_occ_after: got %0d want 4", occ[1*OW +: OW]); end
    drive('0, '0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      total++; if (m_meta_data !== DB'(32'h1100 + k)) begin bad++; $display("FAIL pp_order[%0d]: got %0h want %0h", k, m_meta_data, 32'h1100 + k); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) begin
      push1(2, DB'(32'h500 + k), 1'b0);
      step();
    end
    drive('0, '0, 1'b0);
    total++; if (occ[2*OW +: OW] !== 4'd5) begin bad++; $display("FAIL mid_occ_before: got %0d want 5", occ[2*OW +: OW]); end
    #2 aresetn = 1'b0;
    #1;
    total++; if (m_meta_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0h want 0", m_meta_valid); end
    total++; if (occ !== '0) begin bad++; $display("FAIL mid_occ: got %0h want 0", occ); end
    total++; if (s_meta_ready !== '0) begin bad++; $display("FAIL mid_ready: got %0h want 0", s_meta_ready); end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    drive('0, '0, 1'b1);
    step();
    total++; if (m_meta_valid !== 1'b0) begin bad++; $display("FAIL mid_stale: got %0h want 0", m_meta_valid); end
    total++; if (s_meta_ready !== 4'hF) begin bad++; $display("FAIL mid_ready_after: got %0h want f", s_meta_ready); end
  endtask

  task automatic test_stats();
    logic [NC*32-1:0] exp_cnt;
    for (int k = 0; k < 10; k++) begin
      push1(0, DB'(32'hC000 + k), 1'b1);
      step();
    end
    drive('0, '0, 1'b1);
    repeat (2) step();
    exp_cnt = '0;
    exp_cnt[31:0] = STATS ? 32'd10 : 32'd0;
    total++; if (deq_cnt !== exp_cnt) begin bad++; $display("FAIL stats_cnt: got %0h want %0h", deq_cnt, exp_cnt); end
    total++; if (deq_cnt !== e_deq) begin bad++; $display("FAIL stats_model: got %0h want %0h", deq_cnt, e_deq); end
  endtask

  task automatic test_random();
    logic [NC*DB-1:0] d;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NC; i++) d[i*DB +: DB] = {$urandom, $urandom};
      drive(NC'($urandom), d, (n < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      total++; if (m_meta_valid !== e_valid) begin bad++; $display("FAIL rnd_valid@%0d: got %0h want %0h", n, m_meta_valid, e_valid); end
      if (e_valid) begin
        total++; if (m_meta_chan !== CW'(e_chan)) begin bad++; $display("FAIL rnd_chan@%0d: got %0d want %0d", n, m_meta_chan, e_chan); end
        total++; if (m_meta_data !== e_data) begin bad++; $display("FAIL rnd_data@%0d: got %0h want %0h", n, m_meta_data, e_data); end
      end
      total++; if (s_meta_ready !== e_ready) begin bad++; $display("FAIL rnd_ready@%0d: got %0h want %0h", n, s_meta_ready, e_ready); end
      total++; if (occ !== e_occ) begin bad++; $display("FAIL rnd_occ@%0d: got %0h want %0h", n, occ, e_occ); end
      total++; if (afull !== e_afull) begin bad++; $display("FAIL rnd_afull@%0d: got %0h want %0h", n, afull, e_afull); end
      total++; if (deq_cnt !== e_deq) begin bad++; $display("FAIL rnd_deq_cnt@%0d: got %0h want %0h", n, deq_cnt, e_deq); end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rr_order();
    test_fill();
    test_no_preempt();
    test_push_pop();
    test_reset_mid();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
